// File: rtl/sos_pkg.sv
// Shared constants for the SOS key trigger and the SOS buzzer sequencer.
// Holds the key FSM state type, timebase widths and the SOS element durations.
package sos_pkg;

    localparam int unsigned T1MS_DEFAULT = 49_999;
    localparam int unsigned CYC_W        = 16;
    localparam int unsigned MS_W         = 12;

    // SOS element durations in ms, shared with the downstream sequencer
    localparam int unsigned SOS_DOT_MS  = 100;
    localparam int unsigned SOS_GAP_MS  = 50;
    localparam int unsigned SOS_DASH_MS = 300;

    typedef enum logic [1:0] {
        KEY_IDLE      = 2'd0,
        KEY_PRESS_DEB = 2'd1,
        KEY_HELD      = 2'd2,
        KEY_REL_DEB   = 2'd3
    } key_state_t;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond timebase: a cycle counter wrapping at T1MS feeds a saturating ms counter.
// A synchronous clear restarts both counters from zero.
module ms_tick_gen
    import sos_pkg::*;
#(
    parameter int unsigned T1MS = T1MS_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    output logic            tick_o,
    output logic [MS_W-1:0] ms_o
);

    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [MS_W-1:0]  ms_q, ms_d;

    // tick_o marks the last cycle of the current ms
    assign tick_o = (cyc_q == CYC_W'(T1MS));
    assign ms_o   = ms_q;

    always_comb begin
        cyc_d = tick_o ? '0 : cyc_q + CYC_W'(1);
        ms_d  = ms_q;
        if (tick_o && (ms_q != '1)) begin
            ms_d = ms_q + MS_W'(1);
        end
        if (clr_i) begin
            cyc_d = '0;
            ms_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_q <= '0;
            ms_q  <= '0;
        end else begin
            cyc_q <= cyc_d;
            ms_q  <= ms_d;
        end
    end

endmodule

// File: rtl/key_sos_trigger_module.sv
// Debounced active-low key that emits a one-cycle SOS_En request per clean press.
// Optional auto-repeat while held is enabled by defining KEY_REPEAT_EN.
module key_sos_trigger_module
    import sos_pkg::*;
#(
    parameter int unsigned T1MS             = T1MS_DEFAULT,
    parameter int unsigned DEBOUNCE_MS      = 10,
    parameter int unsigned REPEAT_DELAY_MS  = 1000,
    parameter int unsigned REPEAT_PERIOD_MS = 2000
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic Key_In,
    output logic SOS_En,
    output logic Key_Pressed
);

    if (DEBOUNCE_MS == 0 || DEBOUNCE_MS > 4095 || REPEAT_DELAY_MS == 0 ||
        REPEAT_DELAY_MS > 4095 || REPEAT_PERIOD_MS == 0 || REPEAT_PERIOD_MS > 4095 ||
        T1MS > 65535) begin : g_bad_cfg
        $error("key_sos_trigger_module: timing parameter out of range");
    end

    logic            sync1_q, sync2_q;
    logic            key_s;
    key_state_t      state_q, state_d;
    logic            sos_q, sos_d;
    logic            kp_q, kp_d;
    logic            tick;
    logic [MS_W-1:0] ms_cnt;
    logic            ms_clr;
    logic            deb_done;

    assign key_s = sync2_q;

    ms_tick_gen #(
        .T1MS(T1MS)
    ) u_ms_tick (
        .clk_i (CLK),
        .rst_ni(RST_n),
        .clr_i (ms_clr),
        .tick_o(tick),
        .ms_o  (ms_cnt)
    );

    // Fire on the edge where the ms counter would reach the target, so the
    // transition lands exactly DEBOUNCE_MS*(T1MS+1) cycles after state entry.
    assign deb_done = tick && (ms_cnt == MS_W'(DEBOUNCE_MS - 1));

`ifdef KEY_REPEAT_EN
    logic rep_first_q, rep_first_d;
    logic rep_fire;

    assign rep_fire = (state_q == KEY_HELD) && !key_s && tick &&
                      (ms_cnt == (rep_first_q ? MS_W'(REPEAT_DELAY_MS - 1)
                                              : MS_W'(REPEAT_PERIOD_MS - 1)));

    always_comb begin
        rep_first_d = rep_first_q;
        if (state_d == KEY_HELD && state_q != KEY_HELD) begin
            rep_first_d = 1'b1;
        end else if (rep_fire) begin
            rep_first_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            rep_first_q <= 1'b1;
        end else begin
            rep_first_q <= rep_first_d;
        end
    end

    assign ms_clr = (state_d != state_q) || rep_fire;
`else
    assign ms_clr = (state_d != state_q);
`endif

    always_comb begin
        state_d = state_q;
        sos_d   = 1'b0;
        unique case (state_q)
            KEY_IDLE: begin
                if (!key_s) state_d = KEY_PRESS_DEB;
            end
            KEY_PRESS_DEB: begin
                if (key_s) begin
                    state_d = KEY_IDLE;
                end else if (deb_done) begin
                    state_d = KEY_HELD;
                    sos_d   = 1'b1;
                end
            end
            KEY_HELD: begin
                if (key_s) begin
                    state_d = KEY_REL_DEB;
`ifdef KEY_REPEAT_EN
                end else if (rep_fire) begin
                    sos_d = 1'b1;
`endif
                end
            end
            KEY_REL_DEB: begin
                if (!key_s) begin
                    state_d = KEY_HELD;
                end else if (deb_done) begin
                    state_d = KEY_IDLE;
                end
            end
            default: state_d = KEY_IDLE;
        endcase
        kp_d = (state_d == KEY_HELD) || (state_d == KEY_REL_DEB);
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= KEY_IDLE;
            sos_q   <= 1'b0;
            kp_q    <= 1'b0;
        end else begin
            sync1_q <= Key_In;
            sync2_q <= sync1_q;
            state_q <= state_d;
            sos_q   <= sos_d;
            kp_q    <= kp_d;
        end
    end

    assign SOS_En      = sos_q;
    assign Key_Pressed = kp_q;

endmodule

// File: tb/tb_key_sos_trigger_module.sv
// Self-checking bench for key_sos_trigger_module with a cycle-count reference model.
// Build with KEY_REPEAT_EN defined to exercise the auto-repeat expectations.
module tb_key_sos_trigger_module;

    localparam int unsigned T1MS    = 9;
    localparam int unsigned DEB_MS  = 3;
    localparam int unsigned RDLY_MS = 5;
    localparam int unsigned RPER_MS = 4;
    localparam int DEB_CYC  = DEB_MS * (T1MS + 1);
`ifdef KEY_REPEAT_EN
    localparam int RDLY_CYC = RDLY_MS * (T1MS + 1);
    localparam int RPER_CYC = RPER_MS * (T1MS + 1);
`endif

    logic CLK    = 1'b0;
    logic RST_n  = 1'b1;
    logic Key_In = 1'b1;
    logic SOS_En;
    logic Key_Pressed;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    key_sos_trigger_module #(
        .T1MS            (T1MS),
        .DEBOUNCE_MS     (DEB_MS),
        .REPEAT_DELAY_MS (RDLY_MS),
        .REPEAT_PERIOD_MS(RPER_MS)
    ) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .Key_In     (Key_In),
        .SOS_En     (SOS_En),
        .Key_Pressed(Key_Pressed)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Reference: count consecutive synchronised samples at the awaited level;
    // a press/release is accepted once DEB_CYC+1 samples agree.
    logic m_s1, m_s2, m_pressed, m_sos;
    int   m_low, m_high;
`ifdef KEY_REPEAT_EN
    int   m_held, m_target;
`endif

    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_pressed = 1'b0; m_sos = 1'b0;
            m_low = 0; m_high = 0;
`ifdef KEY_REPEAT_EN
            m_held = 0; m_target = RDLY_CYC;
`endif
        end else begin
            m_sos = 1'b0;
            if (!m_pressed) begin
                m_low = m_s2 ? 0 : m_low + 1;
                if (m_low > DEB_CYC) begin
                    m_pressed = 1'b1; m_sos = 1'b1; m_low = 0; m_high = 0;
`ifdef KEY_REPEAT_EN
                    m_held = 0; m_target = RDLY_CYC;
`endif
                end
            end else if (m_s2) begin
                m_high = m_high + 1;
                if (m_high > DEB_CYC) begin
                    m_pressed = 1'b0; m_high = 0;
                end
            end else if (m_high != 0) begin
                m_high = 0;
`ifdef KEY_REPEAT_EN
                m_held = 0; m_target = RDLY_CYC;
`endif
            end else begin
`ifdef KEY_REPEAT_EN
                m_held = m_held + 1;
                if (m_held == m_target) begin
                    m_sos = 1'b1; m_held = 0; m_target = RPER_CYC;
                end
`endif
            end
            m_s2 = m_s1;
            m_s1 = Key_In;
        end
    end

    typedef struct {
        int   c;
        logic sos;
        logic kp;
        logic esos;
        logic ekp;
    } smp_t;
    smp_t smp[$];

    // Drives a level for n cycles and logs DUT and model outputs on each falling edge.
    task automatic hold(input logic lvl, input int n);
        Key_In = lvl;
        repeat (n) begin
            @(negedge CLK);
            smp.push_back('{c: cyc, sos: SOS_En, kp: Key_Pressed, esos: m_sos, ekp: m_pressed});
        end
    endtask

    task automatic test_reset();
        #2 RST_n = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            checks++;
            if (SOS_En !== 1'b0) begin
                failures++;
                $display("FAIL reset_sos got=%b exp=0", SOS_En);
            end
            checks++;
            if (Key_Pressed !== 1'b0) begin
                failures++;
                $display("FAIL reset_kp got=%b exp=0", Key_Pressed);
            end
        end
        RST_n = 1'b1;
        smp.delete();
        hold(1'b1, 10);
        foreach (smp[i]) begin
            checks++;
            if ({smp[i].sos, smp[i].kp} !== 2'b00) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%b%b exp=00", smp[i].c, smp[i].sos, smp[i].kp);
            end
        end
    endtask

    task automatic test_clean_press();
        int c0, c1, rise, fall;
        int pc[$];
        smp.delete();
        c0 = cyc;
        hold(1'b0, 100);
        c1 = cyc;
        hold(1'b1, 60);
        rise = -1; fall = -1;
        foreach (smp[i]) begin
            checks++;
            if ({smp[i].sos, smp[i].kp} !== {smp[i].esos, smp[i].ekp}) begin
                failures++;
                $display("FAIL clean_model cyc=%0d got=%b%b exp=%b%b", smp[i].c,
                         smp[i].sos, smp[i].kp, smp[i].esos, smp[i].ekp);
            end
            if (smp[i].sos === 1'b1) pc.push_back(smp[i].c);
            if (rise < 0 && smp[i].kp === 1'b1) rise = smp[i].c;
            if (fall < 0 && smp[i].c > c1 && smp[i].kp === 1'b0) fall = smp[i].c;
        end
        checks++;
        if (pc.size() != 1) begin
            failures++;
            $display("FAIL clean_pulse_count got=%0d exp=1", pc.size());
        end
        if (pc.size() >= 1) begin
            checks++;
            if (pc[0] - (c0 + 1) != 32) begin
                failures++;
                $display("FAIL clean_pulse_delay got=%0d exp=32", pc[0] - (c0 + 1));
            end
        end
        checks++;
        if (rise != c0 + 33) begin
            failures++;
            $display("FAIL clean_kp_rise got=%0d exp=%0d", rise, c0 + 33);
        end
        checks++;
        if (fall != c1 + 33) begin
            failures++;
            $display("FAIL clean_kp_fall got=%0d exp=%0d", fall, c1 + 33);
        end
    endtask

    task automatic test_bounce();
        int np, nkp;
        smp.delete();
        hold(1'b0, 20); hold(1'b1, 5); hold(1'b0, 20); hold(1'b1, 40);
        for (int i = 0; i < 8; i++) begin
            hold(1'b0, int'($urandom_range(1, 28)));
            hold(1'b1, int'($urandom_range(1, 28)));
        end
        hold(1'b1, 40);
        np = 0; nkp = 0;
        foreach (smp[i]) begin
            checks++;
            if ({smp[i].sos, smp[i].kp} !== {smp[i].esos, smp[i].ekp}) begin
                failures++;
                $display("FAIL bounce_model cyc=%0d got=%b%b exp=%b%b", smp[i].c,
                         smp[i].sos, smp[i].kp, smp[i].esos, smp[i].ekp);
            end
            if (smp[i].sos !== 1'b0) np++;
            if (smp[i].kp !== 1'b0) nkp++;
        end
        checks++;
        if (np != 0) begin
            failures++;
            $display("FAIL bounce_pulses got=%0d exp=0", np);
        end
        checks++;
        if (nkp != 0) begin
            failures++;
            $display("FAIL bounce_kp_cycles got=%0d exp=0", nkp);
        end
    endtask

    task automatic test_release_bounce();
        int c1, fall;
        int pc[$];
        smp.delete();
        hold(1'b0, 60); hold(1'b1, 10); hold(1'b0, 10);
        c1 = cyc;
        hold(1'b1, 60);
        fall = -1;
        foreach (smp[i]) begin
            checks++;
            if ({smp[i].sos, smp[i].kp} !== {smp[i].esos, smp[i].ekp}) begin
                failures++;
                $display("FAIL relb_model cyc=%0d got=%b%b exp=%b%b", smp[i].c,
                         smp[i].sos, smp[i].kp, smp[i].esos, smp[i].ekp);
            end
            if (smp[i].sos === 1'b1) pc.push_back(smp[i].c);
            if (fall < 0 && pc.size() > 0 && smp[i].kp !== 1'b1) fall = smp[i].c;
        end
        checks++;
        if (pc.size() != 1) begin
            failures++;
            $display("FAIL relb_pulse_count got=%0d exp=1", pc.size());
        end
        checks++;
        if (fall != c1 + 33) begin
            failures++;
            $display("FAIL relb_kp_fall got=%0d exp=%0d", fall, c1 + 33);
        end
    endtask

    task automatic test_reset_mid();
        int cr;
        int pc[$];
        smp.delete();
        hold(1'b0, 17);
        RST_n = 1'b0;
        hold(1'b0, 3);
        RST_n = 1'b1;
        cr = cyc;
        hold(1'b0, 60);
        hold(1'b1, 50);
        foreach (smp[i]) begin
            checks++;
            if ({smp[i].sos, smp[i].kp} !== {smp[i].esos, smp[i].ekp}) begin
                failures++;
                $display("FAIL rstmid_model cyc=%0d got=%b%b exp=%b%b", smp[i].c,
                         smp[i].sos, smp[i].kp, smp[i].esos, smp[i].ekp);
            end
            if (smp[i].sos === 1'b1) pc.push_back(smp[i].c);
        end
        checks++;
        if (pc.size() != 1) begin
            failures++;
            $display("FAIL rstmid_pulse_count got=%0d exp=1", pc.size());
        end
        if (pc.size() >= 1) begin
            checks++;
            if (pc[0] != cr + 33) begin
                failures++;
                $display("FAIL rstmid_pulse_time got=%0d exp=%0d", pc[0], cr + 33);
            end
        end
    endtask

    task automatic test_repeat();
        int c0;
        int pc[$];
        int ex[$];
        smp.delete();
        c0 = cyc;
        hold(1'b0, 300);
        hold(1'b1, 60);
        ex.push_back(32);
`ifdef KEY_REPEAT_EN
        for (int t = 32 + 50; t < 302; t += 40) ex.push_back(t);
`endif
        foreach (smp[i]) begin
            checks++;
            if ({smp[i].sos, smp[i].kp} !== {smp[i].esos, smp[i].ekp}) begin
                failures++;
                $display("FAIL repeat_model cyc=%0d got=%b%b exp=%b%b", smp[i].c,
                         smp[i].sos, smp[i].kp, smp[i].esos, smp[i].ekp);
            end
            if (smp[i].sos === 1'b1) pc.push_back(smp[i].c - (c0 + 1));
        end
        checks++;
        if (pc.size() != ex.size()) begin
            failures++;
            $display("FAIL repeat_pulse_count got=%0d exp=%0d", pc.size(), ex.size());
        end
        for (int i = 0; i < ex.size() && i < pc.size(); i++) begin
            checks++;
            if (pc[i] != ex[i]) begin
                failures++;
                $display("FAIL repeat_pulse_offset idx=%0d got=%0d exp=%0d", i, pc[i], ex[i]);
            end
        end
    endtask

    task automatic test_random();
        logic lvl;
        smp.delete();
        lvl = 1'b0;
        for (int i = 0; i < 30; i++) begin
            hold(lvl, int'($urandom_range(1, 80)));
            lvl = ~lvl;
        end
        hold(1'b1, 50);
        foreach (smp[i]) begin
            checks++;
            if ({smp[i].sos, smp[i].kp} !== {smp[i].esos, smp[i].ekp}) begin
                failures++;
                $display("FAIL random_model cyc=%0d got=%b%b exp=%b%b", smp[i].c,
                         smp[i].sos, smp[i].kp, smp[i].esos, smp[i].ekp);
            end
            if (i > 0) begin
                checks++;
                if (smp[i].sos === 1'b1 && smp[i-1].sos === 1'b1) begin
                    failures++;
                    $display("FAIL random_double_pulse cyc=%0d got=11 exp=not_11", smp[i].c);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_reset_mid();
        test_repeat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
